store_narrow_buffer: RTL and testbench
======================================

Name: store_narrow_buffer

Overview:
- Store-side counterpart of the immediate/data extender: narrows a 32-bit register value to word, halfword or byte writes for sw/sh/sb.
- Generates byte enables and lane-replicated write data, then queues each write in a small FIFO.
- The FIFO drains to the data memory over a valid/ready handshake.
- Sits between the datapath's store issue point and DM; it decouples the core from DM stalls.

Parameters:
- DEPTH, 2, number of FIFO entries (power of two, ≥2).
- AW, 32, address width; DM addresses are word-aligned (low 2 bits zero).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  block can accept a request this cycle.
- req_op  input  2  00 = sw, 01 = sh, 10 = sb, 11 = reserved.
- req_addr  input  AW  byte address.
- req_wdata  input  32  register value (rt).
- dm_valid  output  1  head entry valid.
- dm_ready  input  1  DM accepts the head entry.
- dm_addr  output  AW  word address, {req_addr[AW-1:2], 2'b00}.
- dm_be  output  4  byte enables; bit k = byte lane k, i.e. data bits [8k+7:8k].
- dm_wdata  output  32  lane-replicated write data.
- err  output  1  one-cycle pulse flagging a rejected request.
- err_addr  output  AW  address of the most recent rejected request.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, reset = 0): FIFO emptied, count = 0, dm_valid = 0, dm_be = 0, dm_addr = 0, dm_wdata = 0, err = 0, err_addr = 0.
- Handshakes:
  - Request accepted when req_valid & req_ready.
  - Entry popped when dm_valid & dm_ready.
  - req_ready = (count != DEPTH), driven from registered state; it does not depend on dm_ready in the same cycle.
  - dm_valid = (count != 0).
  - dm_* driven from the head entry registers; they must be stable while dm_valid & !dm_ready.
- Narrowing, little-endian (a = req_addr[1:0]):
  - sw: be = 1111, data = wdata; legal only when a = 00.
  - sh: a = 00 → be = 0011; a = 10 → be = 1100; data = {2{wdata[15:0]}}; a[0] = 1 is illegal.
  - sb: be = 0001 << a; data = {4{wdata[7:0]}}.
  - reserved op, or any illegal alignment: the request is still accepted (handshake completes) but is not enqueued. err = 1 in the following cycle and err_addr captures req_addr.
- Latency: an accepted legal store is visible on dm_valid the next cycle at the earliest, i.e. one cycle through an empty FIFO.
- Simultaneous push and pop: count unchanged; the head advances and the new entry is written at the tail.
- Push when empty and pop in the same cycle: impossible, since dm_valid = 0.
- Full: req_ready = 0. A pop in that cycle makes req_ready = 1 on the next cycle.
- Pointers: wrap modulo DEPTH.
- Reset mid-operation: all queued entries are discarded with no partial DM write; dm_valid falls asynchronously.
- dm_ready while dm_valid = 0: ignored.

Optional Feature:
- Macro: STORE_MERGE_EN.
- Defined:
  - A legal request whose word address equals the youngest entry's dm_addr is merged into that entry instead of being pushed: bytes are overwritten where the new be = 1, and be becomes the OR of old and new.
  - Merging is allowed only if that entry is not being popped in the same cycle.
  - Merge is also permitted when full, so req_ready = !full | merge_hit.
  - count does not change on a merge.
- Undefined: every legal request occupies its own entry; no address comparison logic is built.

Test Plan:
1. sb, addr = 0x0000_1003, wdata = 0x1234_56AB, dm_ready = 1 → next cycle dm_valid = 1, dm_addr = 0x0000_1000, dm_be = 1000, dm_wdata = 0xABAB_ABAB; popped; count returns to 0.
2. sh, addr = 0x0000_2002, wdata = 0xFFFF_BEEF → dm_be = 1100, dm_wdata = 0xBEEF_BEEF. Then sw, addr = 0x0000_2001 → no enqueue, err pulses for 1 cycle, err_addr = 0x0000_2001.
3. dm_ready = 0, three sw back-to-back with DEPTH = 2 → count = 2, req_ready = 0 on the third; raise dm_ready → the third is accepted the cycle after the first pop; DM order preserved.
4. FIFO at count = 1, push and pop in the same cycle → count stays 1, dm_* shows the second entry next cycle.
5. Assert reset = 0 asynchronously mid-cycle with count = 2 → dm_valid, count and err drop to 0 immediately; after release, no stale entry appears on DM.
6. STORE_MERGE_EN, dm_ready = 0: sb 0x3000 data 0x11, then sb 0x3002 data 0x33 → count = 1, dm_be = 0101, dm_wdata[23:16] = 0x33, dm_wdata[7:0] = 0x11.

Source files
------------

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows sw/sh/sb stores to byte-enabled DM writes queued in a FIFO; define STORE_MERGE_EN to merge same-word stores into the youngest entry
module store_narrow_buffer #(
   parameter int DEPTH = 2,
   parameter int AW = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [AW-1:0]          req_addr,
   input  logic [31:0]            req_wdata,
   output logic                   dm_valid,
   input  logic                   dm_ready,
   output logic [AW-1:0]          dm_addr,
   output logic [3:0]             dm_be,
   output logic [31:0]            dm_wdata,
   output logic                   err,
   output logic [AW-1:0]          err_addr,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [AW-1:0] addr_q [DEPTH];
   logic [3:0] be_q [DEPTH];
   logic [31:0] data_q [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [1:0] a;
   logic legal, full, accept, push, pop, merge_hit;
   logic [3:0] be;
   logic [31:0] data;
   logic [AW-1:0] waddr;
   assign a = req_addr[1:0];
   assign waddr = {req_addr[AW-1:2], 2'b00};
   // lane enables, replicated data and alignment legality of the incoming store
   always_comb begin
      legal = req_op == 2'd0 ? a == 2'd0 : req_op == 2'd1 ? !a[0] : req_op == 2'd2;
      be = req_op == 2'd0 ? 4'hf : req_op == 2'd1 ? (a[1] ? 4'hc : 4'h3) : 4'b0001 << a;
      data = req_op == 2'd0 ? req_wdata : req_op == 2'd1 ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
   end
`ifdef STORE_MERGE_EN
   logic [PW-1:0] tail;
   assign tail = wr_ptr - PW'(1);
   assign merge_hit = legal && count != '0 && addr_q[tail] == waddr && !(pop && count == CW'(1));
`else
   assign merge_hit = 1'b0;
`endif
   assign full = count == CW'(DEPTH);
   assign req_ready = !full || merge_hit;
   assign dm_valid = count != '0;
   assign accept = req_valid && req_ready;
   assign push = accept && legal && !merge_hit;
   assign pop = dm_valid && dm_ready;
   assign dm_addr = addr_q[rd_ptr];
   assign dm_be = be_q[rd_ptr];
   assign dm_wdata = data_q[rd_ptr];
   // FIFO storage, pointers, occupancy and rejected-request reporting
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         err <= 1'b0;
         err_addr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            be_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         err <= accept && !legal;
         if (accept && !legal) err_addr <= req_addr;
         if (push) begin
            addr_q[wr_ptr] <= waddr;
            be_q[wr_ptr] <= be;
            data_q[wr_ptr] <= data;
            wr_ptr <= wr_ptr + PW'(1);
         end
`ifdef STORE_MERGE_EN
         if (accept && merge_hit) begin
            be_q[tail] <= be_q[tail] | be;
            for (int k = 0; k < 4; k++)
               if (be[k]) data_q[tail][8*k +: 8] <= data[8*k +: 8];
         end
`endif
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: tb/tb_store_narrow_buffer.sv
// tb_store_narrow_buffer: directed self-checking bench for store_narrow_buffer
module tb_store_narrow_buffer;
   logic clk = 1'b0;
   logic reset;
   logic req_valid, req_ready, dm_valid, dm_ready, err;
   logic [1:0] req_op;
   logic [31:0] req_addr, req_wdata, dm_addr, dm_wdata, err_addr;
   logic [3:0] dm_be;
   logic [1:0] count;
   int passed = 0;
   int total = 0;

   store_narrow_buffer #(.DEPTH(2), .AW(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_addr(dm_addr), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .err(err), .err_addr(err_addr), .count(count)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
      req_valid = 1'b1;
      req_op = op;
      req_addr = addr;
      req_wdata = wd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total++; if (count !== 2'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
      total++; if (dm_valid !== 1'b0) $display("FAIL rst_dm_valid got %b exp 0", dm_valid); else passed++;
      total++; if (dm_be !== 4'h0) $display("FAIL rst_dm_be got %b exp 0000", dm_be); else passed++;
      total++; if (dm_addr !== 32'h0) $display("FAIL rst_dm_addr got %h exp 0", dm_addr); else passed++;
      total++; if (dm_wdata !== 32'h0) $display("FAIL rst_dm_wdata got %h exp 0", dm_wdata); else passed++;
      total++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else passed++;
      total++; if (err_addr !== 32'h0) $display("FAIL rst_err_addr got %h exp 0", err_addr); else passed++;
      total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b exp 1", req_ready); else passed++;
   endtask

   task automatic test_sb();
      dm_ready = 1'b1;
      drive(2'd2, 32'h0000_1003, 32'h1234_56AB);
      step();
      req_valid = 1'b0;
      total++; if (dm_valid !== 1'b1) $display("FAIL sb_valid got %b exp 1", dm_valid); else passed++;
      total++; if (dm_addr !== 32'h0000_1000) $display("FAIL sb_addr got %h exp 00001000", dm_addr); else passed++;
      total++; if (dm_be !== 4'b1000) $display("FAIL sb_be got %b exp 1000", dm_be); else passed++;
      total++; if (dm_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata got %h exp ababab ab", dm_wdata); else passed++;
      step();
      total++; if (count !== 2'd0) $display("FAIL sb_drain_count got %0d exp 0", count); else passed++;
      total++; if (dm_valid !== 1'b0) $display("FAIL sb_drain_valid got %b exp 0", dm_valid); else passed++;
   endtask

   task automatic test_sh_err();
      dm_ready = 1'b0;
      drive(2'd1, 32'h0000_2002, 32'hFFFF_BEEF);
      step();
      total++; if (dm_be !== 4'b1100) $display("FAIL sh_be got %b exp 1100", dm_be); else passed++;
      total++; if (dm_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_wdata got %h exp beefbeef", dm_wdata); else passed++;
      drive(2'd0, 32'h0000_2001, 32'h0BAD_0BAD);
      total++; if (req_ready !== 1'b1) $display("FAIL err_req_ready got %b exp 1", req_ready); else passed++;
      step();
      req_valid = 1'b0;
      total++; if (err !== 1'b1) $display("FAIL err_pulse got %b exp 1", err); else passed++;
      total++; if (err_addr !== 32'h0000_2001) $display("FAIL err_addr got %h exp 00002001", err_addr); else passed++;
      total++; if (count !== 2'd1) $display("FAIL err_no_enqueue got %0d exp 1", count); else passed++;
      step();
      total++; if (err !== 1'b0) $display("FAIL err_one_cycle got %b exp 0", err); else passed++;
      drive(2'd3, 32'h0000_2004, 32'h0);
      step();
      req_valid = 1'b0;
      total++; if (err !== 1'b1 || err_addr !== 32'h0000_2004) $display("FAIL err_reserved got %b/%h exp 1/00002004", err, err_addr); else passed++;
      total++; if (count !== 2'd1) $display("FAIL err_reserved_count got %0d exp 1", count); else passed++;
      dm_ready = 1'b1;
      step();
      total++; if (count !== 2'd0) $display("FAIL sh_drain got %0d exp 0", count); else passed++;
   endtask

   task automatic test_narrow();
      logic [1:0] ops [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
      logic [31:0] adr [7] = '{32'h7000, 32'h7000, 32'h7001, 32'h7002, 32'h7003, 32'h7002, 32'h7000};
      logic [31:0] wds [7] = '{32'hDEAD_BEEF, 32'h1234_ABCD, 32'h0000_005A, 32'h0000_00C3, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
      logic [3:0] ebe [7] = '{4'hF, 4'h3, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0};
      logic [31:0] ewd [7] = '{32'hDEAD_BEEF, 32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hC3C3_C3C3, 32'h0, 32'h0, 32'h0};
      dm_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(ops[i], adr[i], wds[i]);
         step();
         req_valid = 1'b0;
         if (ebe[i] != 4'h0) begin
            total++; if (dm_valid !== 1'b1 || dm_be !== ebe[i] || dm_wdata !== ewd[i] || dm_addr !== 32'h7000)
               $display("FAIL narrow_%0d got v=%b be=%b d=%h a=%h exp v=1 be=%b d=%h a=00007000", i, dm_valid, dm_be, dm_wdata, dm_addr, ebe[i], ewd[i]);
            else passed++;
         end else begin
            total++; if (err !== 1'b1 || dm_valid !== 1'b0 || err_addr !== adr[i])
               $display("FAIL narrow_err_%0d got err=%b v=%b ea=%h exp err=1 v=0 ea=%h", i, err, dm_valid, err_addr, adr[i]);
            else passed++;
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      dm_ready = 1'b0;
      drive(2'd0, 32'h0000_4000, 32'hA1A1_A1A1);
      step();
      drive(2'd0, 32'h0000_4004, 32'hA2A2_A2A2);
      step();
      drive(2'd0, 32'h0000_4008, 32'hA3A3_A3A3);
      total++; if (count !== 2'd2) $display("FAIL b2b_full_count got %0d exp 2", count); else passed++;
      total++; if (req_ready !== 1'b0) $display("FAIL b2b_full_ready got %b exp 0", req_ready); else passed++;
      step();
      total++; if (count !== 2'd2 || dm_addr !== 32'h0000_4000) $display("FAIL b2b_hold got %0d/%h exp 2/00004000", count, dm_addr); else passed++;
      dm_ready = 1'b1;
      step();
      total++; if (count !== 2'd1 || req_ready !== 1'b1 || dm_addr !== 32'h0000_4004) $display("FAIL b2b_pop1 got %0d/%b/%h exp 1/1/00004004", count, req_ready, dm_addr); else passed++;
      step();
      req_valid = 1'b0;
      total++; if (count !== 2'd1 || dm_addr !== 32'h0000_4008 || dm_wdata !== 32'hA3A3_A3A3) $display("FAIL b2b_third got %0d/%h/%h exp 1/00004008/a3a3a3a3", count, dm_addr, dm_wdata); else passed++;
      step();
      total++; if (count !== 2'd0) $display("FAIL b2b_drain got %0d exp 0", count); else passed++;
   endtask

   task automatic test_push_pop();
      dm_ready = 1'b0;
      drive(2'd0, 32'h0000_5000, 32'hB1B1_B1B1);
      step();
      dm_ready = 1'b1;
      drive(2'd0, 32'h0000_5004, 32'hB2B2_B2B2);
      step();
      req_valid = 1'b0;
      total++; if (count !== 2'd1) $display("FAIL pp_count got %0d exp 1", count); else passed++;
      total++; if (dm_addr !== 32'h0000_5004 || dm_wdata !== 32'hB2B2_B2B2) $display("FAIL pp_head got %h/%h exp 00005004/b2b2b2b2", dm_addr, dm_wdata); else passed++;
      step();
      total++; if (count !== 2'd0) $display("FAIL pp_drain got %0d exp 0", count); else passed++;
   endtask

   task automatic test_async_reset();
      dm_ready = 1'b0;
      drive(2'd0, 32'h0000_6000, 32'hC1C1_C1C1);
      step();
      drive(2'd0, 32'h0000_6004, 32'hC2C2_C2C2);
      step();
      req_valid = 1'b0;
      total++; if (count !== 2'd2) $display("FAIL ar_pre_count got %0d exp 2", count); else passed++;
      #2 reset = 1'b0;
      #1;
      total++; if (dm_valid !== 1'b0 || count !== 2'd0 || err !== 1'b0) $display("FAIL ar_immediate got v=%b c=%0d e=%b exp 0/0/0", dm_valid, count, err); else passed++;
      @(negedge clk);
      reset = 1'b1;
      step();
      total++; if (dm_valid !== 1'b0 || dm_addr !== 32'h0 || dm_be !== 4'h0) $display("FAIL ar_stale got v=%b a=%h be=%b exp 0/0/0", dm_valid, dm_addr, dm_be); else passed++;
   endtask

   task automatic test_merge();
      dm_ready = 1'b0;
      drive(2'd2, 32'h0000_3000, 32'h0000_0011);
      step();
      drive(2'd2, 32'h0000_3002, 32'h0000_0033);
      step();
      req_valid = 1'b0;
`ifdef STORE_MERGE_EN
      total++; if (count !== 2'd1) $display("FAIL merge_count got %0d exp 1", count); else passed++;
      total++; if (dm_be !== 4'b0101) $display("FAIL merge_be got %b exp 0101", dm_be); else passed++;
      total++; if (dm_wdata[23:16] !== 8'h33 || dm_wdata[7:0] !== 8'h11) $display("FAIL merge_data got %h exp xx33xx11", dm_wdata); else passed++;
`else
      total++; if (count !== 2'd2) $display("FAIL nomerge_count got %0d exp 2", count); else passed++;
      total++; if (dm_be !== 4'b0001 || dm_wdata !== 32'h1111_1111) $display("FAIL nomerge_head got %b/%h exp 0001/11111111", dm_be, dm_wdata); else passed++;
`endif
      dm_ready = 1'b1;
      step();
      step();
      total++; if (count !== 2'd0) $display("FAIL merge_drain got %0d exp 0", count); else passed++;
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 1'b0;
      req_op = 2'd0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      dm_ready = 1'b0;
      step();
      step();
      test_reset();
      @(negedge clk);
      reset = 1'b1;
      step();
      test_sb();
      test_sh_err();
      test_narrow();
      test_back_to_back();
      test_push_pop();
      test_async_reset();
      test_merge();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
